// File: rtl/xorshift128_checker.sv
// Consumer-side checker for a xorshift128 word stream: learns the generator state
// from four words, then predicts each following word and counts matches/mismatches.
module xorshift128_checker #(
    parameter int RESYNC_THRESH = 4,
    parameter int ERR_W         = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [31:0]      match_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       fill_cnt
);
    typedef enum logic {FILL, LOCKED} state_t;

    localparam logic [3:0] THRESH = 4'(RESYNC_THRESH);

    state_t             fsm, fsm_nx;
    logic [31:0]        x, y, z, w;
    logic [31:0]        x_nx, y_nx, z_nx, w_nx;
    logic [31:0]        t, pred, shift_word;
    logic               shift;
    logic [3:0]         consec_err, consec_nx;
    logic [31:0]        match_nx;
    logic [ERR_W-1:0]   err_nx;
    logic [1:0]         fill_nx;
    logic               pulse_nx;

    always_comb begin
        t          = x ^ (x << 11);
        pred       = w ^ (w >> 19) ^ t ^ (t >> 8);
        fsm_nx     = fsm;
        consec_nx  = consec_err;
        match_nx   = match_cnt;
        err_nx     = err_cnt;
        fill_nx    = fill_cnt;
        pulse_nx   = 1'b0;
        shift      = 1'b0;
        shift_word = in_data;
        if (clr) begin
            // the word arriving with clr is dropped; state words are left as is
            fsm_nx    = FILL;
            consec_nx = '0;
            match_nx  = '0;
            err_nx    = '0;
            fill_nx   = '0;
        end else if (in_valid) begin
            shift = 1'b1;
            case (fsm)
                FILL: begin
                    if (fill_cnt == 2'd3) begin
                        fsm_nx    = LOCKED;
                        fill_nx   = '0;
                        consec_nx = '0;
                    end else begin
                        fill_nx = fill_cnt + 2'd1;
                    end
                end
                LOCKED: begin
                    if (in_data == pred) begin
                        match_nx  = match_cnt + 32'd1;
                        consec_nx = '0;
                    end else begin
                        // keep tracking the expected sequence rather than the corrupted word
                        shift_word = pred;
                        pulse_nx   = 1'b1;
                        if (err_cnt != '1)
                            err_nx = err_cnt + 1'b1;
                        if (consec_err + 4'd1 == THRESH) begin
                            fsm_nx    = FILL;
                            fill_nx   = '0;
                            consec_nx = '0;
                        end else begin
                            consec_nx = consec_err + 4'd1;
                        end
                    end
                end
                default: fsm_nx = FILL;
            endcase
        end
        x_nx = shift ? y          : x;
        y_nx = shift ? z          : y;
        z_nx = shift ? w          : z;
        w_nx = shift ? shift_word : w;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm        <= FILL;
            x          <= '0;
            y          <= '0;
            z          <= '0;
            w          <= '0;
            consec_err <= '0;
            match_cnt  <= '0;
            err_cnt    <= '0;
            fill_cnt   <= '0;
            err_pulse  <= 1'b0;
        end else begin
            fsm        <= fsm_nx;
            x          <= x_nx;
            y          <= y_nx;
            z          <= z_nx;
            w          <= w_nx;
            consec_err <= consec_nx;
            match_cnt  <= match_nx;
            err_cnt    <= err_nx;
            fill_cnt   <= fill_nx;
            err_pulse  <= pulse_nx;
        end
    end

    assign locked = (fsm == LOCKED);
endmodule

// File: tb/tb_xorshift128_checker.sv
// Scoreboard bench for xorshift128_checker: stimulus queues expected outputs per
// accepted word, a negedge monitor pops and compares them.
module tb_xorshift128_checker;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0, clr = 1'b0;
    logic [31:0] in_data = '0;
    logic        locked, err_pulse;
    logic [31:0] match_cnt;
    logic [15:0] err_cnt;
    logic [1:0]  fill_cnt;

    logic        v2 = 1'b0, c2 = 1'b0;
    logic [31:0] d2 = '0;
    logic        locked2, pulse2;
    logic [31:0] match2;
    logic [3:0]  err2;
    logic [1:0]  fill2;

    xorshift128_checker dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .match_cnt(match_cnt),
        .err_cnt(err_cnt), .fill_cnt(fill_cnt)
    );

    xorshift128_checker #(.RESYNC_THRESH(15), .ERR_W(4)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(v2), .in_data(d2), .clr(c2),
        .locked(locked2), .err_pulse(pulse2), .match_cnt(match2),
        .err_cnt(err2), .fill_cnt(fill2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lk;
        logic        ep;
        logic [31:0] mc;
        logic [15:0] ec;
        logic [1:0]  fc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        issued  = 1'b0;
    logic [31:0] g[0:399];
    int          gi = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] t;
        t = a ^ (a << 11);
        return d ^ (d >> 19) ^ t ^ (t >> 8);
    endfunction

    always @(posedge clk) issued <= rstn && (in_valid || clr);

    always @(negedge clk) begin
        if (issued) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("locked",    {31'd0, locked},    {31'd0, e.lk});
                check("err_pulse", {31'd0, err_pulse}, {31'd0, e.ep});
                check("match_cnt", match_cnt,          e.mc);
                check("err_cnt",   {16'd0, err_cnt},   {16'd0, e.ec});
                check("fill_cnt",  {30'd0, fill_cnt},  {30'd0, e.fc});
            end
        end else if (rstn) begin
            check("idle_pulse", {31'd0, err_pulse}, 32'd0);
        end
    end

    task automatic push(input logic el, input logic ep, input int em, input int ee, input int ef);
        exp_t e;
        e.lk = el; e.ep = ep; e.mc = 32'(em); e.ec = 16'(ee); e.fc = 2'(ef);
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input logic el, input logic ep,
                        input int em, input int ee, input int ef);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; clr = 1'b0;
        push(el, ep, em, ee, ef);
    endtask

    task automatic do_clr(input logic v, input logic [31:0] d);
        @(negedge clk);
        in_valid = v; in_data = d; clr = 1'b1;
        push(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0; clr = 1'b0;
        end
    endtask

    initial begin
        g[0] = 32'd123456789; g[1] = 32'd3624360069;
        g[2] = 32'd521288629; g[3] = 32'd88675123;
        for (int k = 4; k < 400; k++) g[k] = nxt(g[k-4], g[k-1]);

        @(negedge clk); @(negedge clk);
        check("rst_locked", {31'd0, locked},    32'd0);
        check("rst_pulse",  {31'd0, err_pulse}, 32'd0);
        check("rst_match",  match_cnt,          32'd0);
        check("rst_err",    {16'd0, err_cnt},   32'd0);
        check("rst_fill",   {30'd0, fill_cnt},  32'd0);
        rstn = 1'b1;

        // lock and track: 104 golden words
        for (int i = 0; i < 104; i++)
            send(g[gi++], i >= 3, 1'b0, (i >= 4) ? i - 3 : 0, 0, (i < 3) ? i + 1 : 0);

        // single corruption on the 20th word, then golden words keep matching
        for (int k = 0; k < 19; k++) send(g[gi++], 1'b1, 1'b0, 101 + k, 0, 0);
        send(g[gi++] ^ 32'd1, 1'b1, 1'b1, 119, 1, 0);
        for (int k = 0; k < 10; k++) send(g[gi++], 1'b1, 1'b0, 120 + k, 1, 0);

        // clr with a valid golden word while locked: the word is discarded
        do_clr(1'b1, g[gi++]);

        // relock, 6 matches, then four bad words force loss of lock
        for (int i = 0; i < 4; i++) send(g[gi++], i == 3, 1'b0, 0, 0, (i < 3) ? i + 1 : 0);
        for (int k = 0; k < 6; k++) send(g[gi++], 1'b1, 1'b0, 1 + k, 0, 0);
        for (int k = 0; k < 4; k++) begin
            send(32'hFFFF_FFFF, k != 3, 1'b1, 6, 1 + k, 0);
            gi++;
        end
        for (int i = 0; i < 4; i++) send(g[gi++], i == 3, 1'b0, 6, 4, (i < 3) ? i + 1 : 0);
        for (int k = 0; k < 10; k++) send(g[gi++], 1'b1, 1'b0, 7 + k, 4, 0);

        // gapped valid from a cleared state
        do_clr(1'b0, 32'd0);
        for (int i = 0; i < 50; i++) begin
            idle(int'($urandom_range(0, 1)));
            send(g[gi++], i >= 3, 1'b0, (i >= 4) ? i - 3 : 0, 0, (i < 3) ? i + 1 : 0);
        end
        idle(2);
        check("gap_final_match", match_cnt, 32'd46);
        check("gap_final_err",   {16'd0, err_cnt}, 32'd0);

        // short async reset pulse mid-fill
        do_clr(1'b0, 32'd0);
        send(g[gi++], 1'b0, 1'b0, 0, 0, 1);
        send(g[gi++], 1'b0, 1'b0, 0, 0, 2);
        idle(1);
        check("prefill_cnt", {30'd0, fill_cnt}, 32'd2);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_fill", {30'd0, fill_cnt}, 32'd0);
        check("async_lock", {31'd0, locked},   32'd0);
        #1 rstn = 1'b1;
        for (int i = 0; i < 4; i++) send(g[gi++], i == 3, 1'b0, 0, 0, (i < 3) ? i + 1 : 0);
        for (int k = 0; k < 2; k++) send(g[gi++], 1'b1, 1'b0, 1 + k, 0, 0);
        idle(3);

        // saturation on the narrow instance: 4 fill words then 20 bad words
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 19) begin
                check("sat_resync_lock", {31'd0, locked2}, 32'd0);
                check("sat_resync_err",  {28'd0, err2},    32'd15);
                check("sat_resync_pls",  {31'd0, pulse2},  32'd1);
            end
            v2 = 1'b1;
            d2 = (k < 4) ? g[gi + k] : 32'hFFFF_FFFF;
        end
        @(negedge clk);
        v2 = 1'b0;
        check("sat_err",   {28'd0, err2},    32'd15);
        check("sat_lock",  {31'd0, locked2}, 32'd1);
        check("sat_pulse", {31'd0, pulse2},  32'd1);
        idle(2);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
